// File: rtl/vga_pkg.sv
// Shared VGA constants and the timing bundle that is passed along the overlay chain.
package vga_pkg;

  localparam int HOR_ADDR  = 1280;
  localparam int VER_ADDR  = 1024;
  localparam int HOR_TOTAL = 1688;
  localparam int VER_TOTAL = 1066;

  localparam logic [11:0] KEY_COLOR = 12'hF0F;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
  } vga_tim_t;

endpackage

// File: rtl/timing_delay.sv
// Registered delay line for the VGA timing bundle, used to keep sync and counters aligned
// with an overlay's pixel pipeline.
module timing_delay
  import vga_pkg::vga_tim_t;
#(
  parameter int DEPTH = 2
) (
  input  logic     pclk_in,
  input  logic     rst_in,
  input  vga_tim_t tim_in,
  output vga_tim_t tim_out
);

  vga_tim_t pipe [DEPTH];

  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tim_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tim_out = pipe[DEPTH-1];

endmodule

// File: rtl/draw_player.sv
// Player sprite overlay: latches a clamped position once per frame, addresses the sprite
// ROM in stage 1 and composes ROM data over the background in stage 2.
module draw_player
  import vga_pkg::vga_tim_t;
#(
  parameter int          SPRITE_W  = 32,
  parameter int          SPRITE_H  = 48,
  parameter int          ADDR_W    = 11,
  parameter logic [11:0] KEY_COLOR = vga_pkg::KEY_COLOR,
  parameter int          HOR_ADDR  = vga_pkg::HOR_ADDR,
  parameter int          VER_ADDR  = vga_pkg::VER_ADDR
) (
  input  logic              pclk_in,
  input  logic              rst_in,
  input  logic [10:0]       vcount_in,
  input  logic [10:0]       hcount_in,
  input  logic              vsync_in,
  input  logic              hsync_in,
  input  logic              vblnk_in,
  input  logic              hblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic [10:0]       xpos_in,
  input  logic [10:0]       ypos_in,
  input  logic              mirror_in,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [10:0]       vcount_out,
  output logic [10:0]       hcount_out,
  output logic              vsync_out,
  output logic              hsync_out,
  output logic              vblnk_out,
  output logic              hblnk_out,
  output logic [11:0]       rgb_out
);

  localparam int          XW    = $clog2(SPRITE_W);
  localparam logic [10:0] X_MAX = 11'(HOR_ADDR - SPRITE_W);
  localparam logic [10:0] Y_MAX = 11'(VER_ADDR - SPRITE_H);

  logic        vblnk_prev;
  logic        frame_start;
  logic [10:0] x_lat;
  logic [10:0] y_lat;
  logic        mir_lat;

  logic [11:0]       h12, v12, x12, y12;
  logic [XW-1:0]     rel_x;
  logic [11:0]       rel_y;
  logic [XW-1:0]     ax;
  logic              in_win;
  logic [ADDR_W-1:0] addr_nxt;

  logic        in_win1;
  logic        blank1;
  logic [11:0] rgb1;

  vga_tim_t tim_in;
  vga_tim_t tim_out;

  assign frame_start = vblnk_in & ~vblnk_prev;

  // Position only moves on the vblank rising edge, so a frame never tears.
  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) begin
      vblnk_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
      mir_lat    <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (frame_start) begin
        x_lat   <= (xpos_in > X_MAX) ? X_MAX : xpos_in;
        y_lat   <= (ypos_in > Y_MAX) ? Y_MAX : ypos_in;
        mir_lat <= mirror_in;
      end
    end
  end

  always_comb begin
    h12    = {1'b0, hcount_in};
    v12    = {1'b0, vcount_in};
    x12    = {1'b0, x_lat};
    y12    = {1'b0, y_lat};
    rel_x  = XW'(h12 - x12);
    rel_y  = v12 - y12;
    in_win = (h12 >= x12) && (h12 < x12 + 12'(SPRITE_W)) &&
             (v12 >= y12) && (v12 < y12 + 12'(SPRITE_H));
    ax       = mir_lat ? (XW'(SPRITE_W - 1) - rel_x) : rel_x;
    addr_nxt = ADDR_W'({rel_y, ax});
  end

  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) begin
      pixel_addr <= '0;
      in_win1    <= 1'b0;
      blank1     <= 1'b0;
      rgb1       <= '0;
    end else begin
      if (in_win) pixel_addr <= addr_nxt;
      in_win1 <= in_win;
      blank1  <= vblnk_in | hblnk_in;
      rgb1    <= rgb_in;
    end
  end

  // ROM data arrives one cycle after the address, lining up with the stage-1 flags.
  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) begin
      rgb_out <= '0;
    end else if (blank1) begin
      rgb_out <= 12'h000;
    end else if (in_win1 && (rgb_pixel != KEY_COLOR)) begin
      rgb_out <= rgb_pixel;
    end else begin
      rgb_out <= rgb1;
    end
  end

  always_comb begin
    tim_in        = '0;
    tim_in.vcount = vcount_in;
    tim_in.hcount = hcount_in;
    tim_in.vsync  = vsync_in;
    tim_in.hsync  = hsync_in;
    tim_in.vblnk  = vblnk_in;
    tim_in.hblnk  = hblnk_in;
  end

  timing_delay #(
    .DEPTH (2)
  ) u_timing_delay (
    .pclk_in (pclk_in),
    .rst_in  (rst_in),
    .tim_in  (tim_in),
    .tim_out (tim_out)
  );

  assign vcount_out = tim_out.vcount;
  assign hcount_out = tim_out.hcount;
  assign vsync_out  = tim_out.vsync;
  assign hsync_out  = tim_out.hsync;
  assign vblnk_out  = tim_out.vblnk;
  assign hblnk_out  = tim_out.hblnk;

endmodule

// File: tb/tb_draw_player.sv
// Randomized bench for draw_player: short synthetic frames checked against a
// position/window model with a two-deep expectation queue.
module tb_draw_player;

  localparam logic [11:0] KEY = 12'hF0F;

  logic        pclk_in = 1'b0;
  logic        rst_in;
  logic [10:0] vcount_in, hcount_in, xpos_in, ypos_in;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in, mirror_in;
  logic [11:0] rgb_in, rgb_pixel;
  logic [10:0] pixel_addr;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;

  always #4 pclk_in = ~pclk_in;

  draw_player dut (
    .pclk_in    (pclk_in),
    .rst_in     (rst_in),
    .vcount_in  (vcount_in),
    .hcount_in  (hcount_in),
    .vsync_in   (vsync_in),
    .hsync_in   (hsync_in),
    .vblnk_in   (vblnk_in),
    .hblnk_in   (hblnk_in),
    .rgb_in     (rgb_in),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .mirror_in  (mirror_in),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .vcount_out (vcount_out),
    .hcount_out (hcount_out),
    .vsync_out  (vsync_out),
    .hsync_out  (hsync_out),
    .vblnk_out  (vblnk_out),
    .hblnk_out  (hblnk_out),
    .rgb_out    (rgb_out)
  );

  typedef struct packed {
    logic [25:0] tim;
    logic        blank;
    logic        win;
    logic [11:0] bg;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_x, m_y, m_addr;
  bit   m_mir, m_prev_vb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    q.delete();
    q.push_back('0);
    q.push_back('0);
    m_x = 0; m_y = 0; m_addr = 0; m_mir = 1'b0; m_prev_vb = 1'b0;
  endtask

  task automatic drive_random();
    hcount_in = 11'($urandom); vcount_in = 11'($urandom);
    vsync_in  = 1'($urandom);  hsync_in  = 1'($urandom);
    vblnk_in  = 1'($urandom);  hblnk_in  = 1'($urandom);
    rgb_in    = 12'($urandom); rgb_pixel = 12'($urandom);
    xpos_in   = 11'($urandom); ypos_in   = 11'($urandom);
    mirror_in = 1'($urandom);
  endtask

  // Called just after a falling edge; holds reset for n cycles.
  task automatic do_reset(input int n);
    rst_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_random();
      #1;
      check("reset_tim", 64'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}), 64'd0);
      check("reset_px", 64'({pixel_addr, rgb_out}), 64'd0);
      @(negedge pclk_in);
    end
    rst_in = 1'b1;
    model_reset();
  endtask

  task automatic step(input int hc, input int vc, input bit vb, input bit hb, input bit vs, input bit hs,
                      input logic [11:0] bg, input int xp, input int yp, input bit mir,
                      input logic [11:0] rom);
    exp_t        e, o;
    logic [11:0] exp_rgb;
    bit          win;
    o = q.pop_front();
    // Output reflects inputs of two cycles ago and the ROM word presented one cycle ago.
    if (o.blank)                        exp_rgb = 12'h000;
    else if (o.win && rgb_pixel != KEY) exp_rgb = rgb_pixel;
    else                                exp_rgb = o.bg;
    check("timing", 64'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}), 64'(o.tim));
    check("rgb", 64'(rgb_out), 64'(exp_rgb));
    check("addr", 64'(pixel_addr), 64'(m_addr));

    hcount_in = 11'(hc); vcount_in = 11'(vc);
    vblnk_in  = vb;      hblnk_in  = hb;
    vsync_in  = vs;      hsync_in  = hs;
    rgb_in    = bg;      rgb_pixel = rom;
    xpos_in   = 11'(xp); ypos_in   = 11'(yp);
    mirror_in = mir;

    win = (hc >= m_x) && (hc < m_x + 32) && (vc >= m_y) && (vc < m_y + 48);
    if (win) m_addr = ((vc - m_y) * 32 + (m_mir ? 31 - (hc - m_x) : hc - m_x)) % 2048;
    e.tim   = {11'(vc), 11'(hc), vs, hs, vb, hb};
    e.blank = vb | hb;
    e.win   = win;
    e.bg    = bg;
    q.push_back(e);
    if (vb && !m_prev_vb) begin
      m_x   = (xp > 1248) ? 1248 : xp;
      m_y   = (yp > 976) ? 976 : yp;
      m_mir = mir;
    end
    m_prev_vb = vb;
    @(negedge pclk_in);
  endtask

  // One short frame: 4 vblank cycles, a scan of the window border rows, then
  // mostly near-window random pixels. The x request switches to xp2 from cycle sw on.
  task automatic run_frame(input int len, input int xp, input int yp, input bit mir,
                           input int rom_mode, input int xp2, input int sw);
    for (int i = 0; i < len; i++) begin
      int          hc, vc, x_req, sel, k;
      logic [11:0] rom;
      bit          vb, hb;
      x_req = (i >= sw) ? xp2 : xp;
      vb    = (i < 4);
      hb    = ($urandom_range(0, 9) == 0);
      if (i >= 4 && i < 4 + 4 * 34) begin
        k = i - 4;
        case (k / 34)
          0:       vc = m_y - 1;
          1:       vc = m_y;
          2:       vc = m_y + 47;
          default: vc = m_y + 48;
        endcase
        hc = m_x - 1 + (k % 34);
        hb = 1'b0;
      end else if ($urandom_range(0, 3) != 0) begin
        hc = m_x - 4 + int'($urandom_range(0, 40));
        vc = m_y - 4 + int'($urandom_range(0, 56));
      end else begin
        hc = int'($urandom_range(0, 1687));
        vc = int'($urandom_range(0, 1065));
      end
      if (hc < 0) hc = 0;
      if (vc < 0) vc = 0;
      sel = (rom_mode == 2) ? int'($urandom_range(0, 2)) : rom_mode;
      rom = (sel == 0) ? 12'h0F0 : (sel == 1) ? KEY : 12'($urandom);
      step(hc, vc, vb, hb, 1'($urandom), 1'($urandom), 12'($urandom), x_req, yp, mir, rom);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    drive_random();
    @(negedge pclk_in);
    do_reset(10);

    run_frame(300, 100, 200, 1'b0, 0, 100, 1000);
    run_frame(300, 100, 200, 1'b0, 1, 100, 1000);
    run_frame(300, 100, 200, 1'b1, 2, 100, 1000);
    run_frame(300, 100, 200, 1'b0, 2, 100, 1000);
    run_frame(300, 2000, 1100, 1'b0, 0, 2000, 1000);
    run_frame(300, 1248, 976, 1'b1, 2, 1248, 1000);
    run_frame(300, 0, 0, 1'b1, 2, 0, 1000);
    run_frame(300, 100, 200, 1'b0, 0, 400, 150);
    run_frame(300, 400, 200, 1'b0, 0, 400, 1000);
    run_frame(300, 700, 300, 1'b0, 2, 700, 0);
    run_frame(200, 500, 500, 1'b1, 2, 900, 100);
    do_reset(10);
    run_frame(300, 900, 100, 1'b0, 2, 900, 1000);

    for (int f = 0; f < 15; f++) begin
      int xp, yp;
      xp = int'($urandom_range(0, 2047));
      yp = int'($urandom_range(0, 2047));
      run_frame(300, xp, yp, 1'($urandom), 2, int'($urandom_range(0, 2047)), int'($urandom_range(4, 400)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
